store_buffer: RTL

Posted-store buffer between the execute stage and the byte-addressed data memory. Accepts stores (sb/sh/sw, `DMCtrl` encoding) into a DEPTH-entry FIFO and retires them to the memory write port in cycles with no load on the port. Checks each load against pending stores:
- exact matches are forwarded with the load's sign/zero extension;
- partial overlaps stall the load until the conflicting stores drain.

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/store_buffer_if.sv | 32 +++
 rtl/sb_match.sv | 24 ++
 rtl/store_buffer.sv | 114 +++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared data-memory definitions: DMCtrl encodings, size/extension helpers and
// the store-buffer entry type. The data memory's load decode uses the same constants.
package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  // Widest address any instance may use; entries hold the address zero-extended.
  localparam int unsigned MAX_AW = 64;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] addr;
    logic [31:0]       data;
    logic [2:0]        size;
  } sb_entry_t;

  function automatic logic [2:0] size_bytes(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data, input logic [2:0] ctrl);
    case (ctrl)
      LB:      return {{24{data[7]}}, data[7:0]};
      LH:      return {{16{data[15]}}, data[15:0]};
      LW:      return data;
      LBU:     return {24'h0, data[7:0]};
      LHU:     return {16'h0, data[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic st_legal(input logic [2:0] ctrl);
    return (ctrl == SB) || (ctrl == SH) || (ctrl == SW);
  endfunction

  function automatic logic ld_legal(input logic [2:0] ctrl);
    return (ctrl == LB) || (ctrl == LH) || (ctrl == LW) || (ctrl == LBU) || (ctrl == LHU);
  endfunction

  function automatic logic [3:0] size_be(input logic [2:0] size);
    case (size)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Execute-stage store/load request bundle plus the memory write port of the store buffer.
interface store_buffer_if #(
  parameter int unsigned AW = 32
);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [2:0]    st_ctrl;
  logic          st_ready;

  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [2:0]    ld_ctrl;
  logic          ld_hit;
  logic [31:0]   ld_data;
  logic          ld_stall;

  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic [3:0]    mem_be;

  modport master (
    output st_valid, st_addr, st_data, st_ctrl, ld_valid, ld_addr, ld_ctrl,
    input  st_ready, ld_hit, ld_data, ld_stall, mem_wr_en, mem_addr, mem_wr_data, mem_be
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_ctrl, ld_valid, ld_addr, ld_ctrl,
    output st_ready, ld_hit, ld_data, ld_stall, mem_wr_en, mem_addr, mem_wr_data, mem_be
  );
endinterface

// File: rtl/sb_match.sv
// Per-entry load check: byte-range overlap and exact (same address, same size) match.
module sb_match #(
  parameter int unsigned AW = 32
) (
  input  logic          valid,
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [AW-1:0] ld_addr,
  input  logic [2:0]    ld_size,
  output logic          overlap,
  output logic          exact
);
  logic [AW:0] e_lo, e_hi, l_lo, l_hi;

  // One extra bit so ranges ending past the top of the address space do not wrap.
  always_comb begin
    e_lo    = {1'b0, addr};
    e_hi    = e_lo + {{(AW - 2){1'b0}}, size};
    l_lo    = {1'b0, ld_addr};
    l_hi    = l_lo + {{(AW - 2){1'b0}}, ld_size};
    overlap = valid && (e_lo < l_hi) && (l_lo < e_hi);
    exact   = overlap && (e_lo == l_lo) && (size == ld_size);
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO between execute and data memory, with load forwarding
// (youngest exact match) and stall on any other overlap with pending stores.
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  sb_entry_t     entries_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;

  logic [DEPTH-1:0] overlap, exact;
  logic [2:0]       ld_size;
  logic [PW-1:0]    young;
  logic             found, ld_chk, enq, deq;

  assign ld_size = size_bytes(sb.ld_ctrl);

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    sb_match #(.AW(AW)) u_match (
      .valid   (entries_q[i].valid),
      .addr    (entries_q[i].addr[AW-1:0]),
      .size    (entries_q[i].size),
      .ld_addr (sb.ld_addr),
      .ld_size (ld_size),
      .overlap (overlap[i]),
      .exact   (exact[i])
    );
  end

  if (AW < MAX_AW) begin : g_unused
    logic [DEPTH-1:0] unused_addr_hi;
    for (genvar i = 0; i < DEPTH; i++) begin : g_bit
      assign unused_addr_hi[i] = ^entries_q[i].addr[MAX_AW-1:AW];
    end
  end

  // Scan oldest to youngest so the last overlapping entry seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    found = 1'b0;
    young = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q + k[PW-1:0];
      if (overlap[idx]) begin
        found = 1'b1;
        young = idx;
      end
    end
  end

  always_comb begin
    ld_chk       = sb.ld_valid && ld_legal(sb.ld_ctrl);
    sb.ld_hit    = ld_chk && found && exact[young];
    sb.ld_stall  = ld_chk && found && !exact[young];
    sb.ld_data   = sb.ld_hit ? extend(entries_q[young].data, sb.ld_ctrl) : 32'h0;

    sb.st_ready  = count_q < DEPTH_C;
    enq          = sb.st_valid && sb.st_ready && st_legal(sb.st_ctrl);
    deq          = (count_q != '0) && (!sb.ld_valid || sb.ld_stall);

    sb.mem_wr_en   = deq;
    sb.mem_addr    = entries_q[rptr_q].addr[AW-1:0];
    sb.mem_wr_data = entries_q[rptr_q].data;
    sb.mem_be      = size_be(entries_q[rptr_q].size);
  end

  always_comb begin
    wptr_d  = enq ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = deq ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (!enq && deq) begin
      count_d = count_q - 1'b1;
    end
  end

  // enq and deq never target the same slot: enq needs not-full, deq needs not-empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      if (deq) begin
        entries_q[rptr_q].valid <= 1'b0;
      end
      if (enq) begin
        entries_q[wptr_q] <= '{
          valid: 1'b1,
          addr:  MAX_AW'(sb.st_addr),
          data:  sb.st_data,
          size:  size_bytes(sb.st_ctrl)
        };
      end
    end
  end
endmodule
